// File: rtl/wb_pkg.sv
// Shared types and default constants for the writeback port arbiter.
package wb_pkg;

   // One buffered register-file write: destination register plus value.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   // Cycles the MDU head may wait behind the pipeline before a forced drain.
   localparam int STARVE_LIMIT_DEF = 4;

   // Number of MDU results the arbiter can hold.
   localparam int FIFO_DEPTH_DEF = 2;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer for MDU results. A per-slot valid vector and the
// destination register of every slot are exported so the parent can check
// decode-stage hazards against everything not yet written back.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  wb_req_t                      push_entry,
   input  logic                         pop,
   output wb_req_t                      head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic [DEPTH-1:0]             entry_valid,
   output logic [DEPTH*5-1:0]           entry_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [DEPTH-1:0]   valid_next;
   logic               do_push;
   logic               do_pop;

   // Never write into a full buffer or read from an empty one.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage holds data only; it needs no reset because validity is tracked separately.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Next slot-valid vector: push and pop never target the same slot.
   always_comb begin
      valid_next = entry_valid;
      if (do_push) begin
         valid_next[wr_ptr] = 1'b1;
      end
      if (do_pop) begin
         valid_next[rd_ptr] = 1'b0;
      end
   end

   // Pointers, occupancy count and slot-valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         entry_valid <= valid_next;
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Flatten the destination registers of all slots for the hazard compare.
   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_rd[i*5 +: 5] = mem[i].rd;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// stage (zero latency, normally wins) and buffered multi-cycle-unit results.
// A starvation counter forces an MDU drain, stalling the pipeline for one
// cycle, once the buffered head has waited STARVE_LIMIT cycles.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_wr_en_WB,
   input  logic [4:0]  pipe_rd_WB,
   input  logic [31:0] write_data_WB,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   input  logic [4:0]  hazard_rd,
   output logic        hazard_hit,
   output logic        pipe_stall_WB,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   wb_req_t               push_entry;
   wb_req_t               head;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  empty;
   logic [FIFO_DEPTH-1:0] entry_valid;
   logic [FIFO_DEPTH*5-1:0] entry_rd;
   logic                  push;
   logic                  pop;
   logic                  live;
   logic                  force_drain;
   logic [3:0]            starve;

   // Ready depends only on the registered count, so a drain in the same
   // cycle cannot open a slot for a result arriving while full.
   assign mdu_ready = (count < CNT_W'(FIFO_DEPTH));
   assign push      = mdu_valid & mdu_ready & ~full;

   assign push_entry.rd   = mdu_rd;
   assign push_entry.data = mdu_data;

   // The head has waited long enough: take the port away from the pipeline.
   assign force_drain   = ~empty & (starve == 4'(STARVE_LIMIT));
   assign pipe_stall_WB = force_drain;

   // A pipeline write to r0 is a no-op and leaves the port free for the MDU.
   assign live = rst_n & pipe_wr_en_WB & (pipe_rd_WB != 5'd0) & ~force_drain;
   assign pop  = ~empty & (force_drain | ~live);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (pop),
      .head        (head),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // Register-file port mux; an MDU result for r0 is dropped silently.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (live) begin
         rf_we    = 1'b1;
         rf_waddr = pipe_rd_WB;
         rf_wdata = write_data_WB;
      end else if (pop && (head.rd != 5'd0)) begin
         rf_we    = 1'b1;
         rf_waddr = head.rd;
         rf_wdata = head.data;
      end
   end

   // Hazard compare against every buffered result, including one leaving this cycle.
   always_comb begin
      hazard_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i] && (entry_rd[i*5 +: 5] == hazard_rd)) begin
            hazard_hit = 1'b1;
         end
      end
      if (hazard_rd == 5'd0) begin
         hazard_hit = 1'b0;
      end
   end

   // Starvation counter: counts cycles a buffered head is passed over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve <= 4'd0;
      end else if (pop || empty) begin
         starve <= 4'd0;
      end else if (starve != 4'hF) begin
         starve <= starve + 4'd1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_wb_port_arbiter;
   localparam int LIMIT = 4;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_wr_en_WB;
   logic [4:0]  pipe_rd_WB;
   logic [31:0] write_data_WB;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic [4:0]  hazard_rd;
   logic        hazard_hit;
   logic        pipe_stall_WB;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks   = 0;
   int failures = 0;

   // Reference model state: pending MDU results in arrival order.
   logic [36:0] mq[$];
   int          starve_m = 0;

   wb_port_arbiter #(
      .STARVE_LIMIT (LIMIT),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pipe_wr_en_WB (pipe_wr_en_WB),
      .pipe_rd_WB    (pipe_rd_WB),
      .write_data_WB (write_data_WB),
      .mdu_valid     (mdu_valid),
      .mdu_rd        (mdu_rd),
      .mdu_data      (mdu_data),
      .mdu_ready     (mdu_ready),
      .hazard_rd     (hazard_rd),
      .hazard_hit    (hazard_hit),
      .pipe_stall_WB (pipe_stall_WB),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare at the falling edge, advance the model.
   task automatic step(input logic wen, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                       input logic [4:0] hrd);
      logic        e_ready, e_stall, e_live, e_pop, e_we, e_hz;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [36:0] hd;
      bit          was_empty;
      pipe_wr_en_WB = wen;
      pipe_rd_WB    = prd;
      write_data_WB = pdata;
      mdu_valid     = mv;
      mdu_rd        = mrd;
      mdu_data      = mdata;
      hazard_rd     = hrd;
      @(negedge clk);
      was_empty = (mq.size() == 0);
      hd        = was_empty ? 37'd0 : mq[0];
      e_ready   = (mq.size() < DEPTH);
      e_stall   = !was_empty && (starve_m == LIMIT);
      e_live    = wen && (prd != 0) && !e_stall;
      e_pop     = !was_empty && (e_stall || !e_live);
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
      if (e_live) begin
         e_we = 1'b1; e_addr = prd; e_data = pdata;
      end else if (e_pop && hd[36:32] != 0) begin
         e_we = 1'b1; e_addr = hd[36:32]; e_data = hd[31:0];
      end
      e_hz = 1'b0;
      foreach (mq[i]) if (hrd != 0 && mq[i][36:32] == hrd) e_hz = 1'b1;
      check("mdu_ready", 32'(mdu_ready), 32'(e_ready));
      check("pipe_stall", 32'(pipe_stall_WB), 32'(e_stall));
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
      check("hazard_hit", 32'(hazard_hit), 32'(e_hz));
      if (e_pop) void'(mq.pop_front());
      if (mv && e_ready) mq.push_back({mrd, mdata});
      if (e_pop || was_empty) starve_m = 0;
      else if (starve_m < 15) starve_m++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
   endtask

   // Hold reset low for one cycle with busy inputs; everything must read idle.
   task automatic pulse_reset();
      rst_n         = 1'b0;
      pipe_wr_en_WB = 1'b1;
      pipe_rd_WB    = 5'd9;
      write_data_WB = 32'hDEAD;
      mdu_valid     = 1'b1;
      mdu_rd        = 5'd4;
      mdu_data      = 32'h44;
      hazard_rd     = 5'd5;
      @(negedge clk);
      check("rst_ready", 32'(mdu_ready), 32'd1);
      check("rst_stall", 32'(pipe_stall_WB), 32'd0);
      check("rst_hazard", 32'(hazard_hit), 32'd0);
      check("rst_we", 32'(rf_we), 32'd0);
      mq.delete();
      starve_m = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      pipe_wr_en_WB = 1'b0; pipe_rd_WB = 5'd0; write_data_WB = 32'd0;
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0; hazard_rd = 5'd0;
      @(posedge clk); #1;
      pulse_reset();

      // Idle pipeline: MDU result written the cycle after acceptance.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
      idle_step();

      // Pipeline busy every cycle: forced drain in the fifth cycle after enqueue.
      step(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77, 5'd7);
      for (int i = 1; i <= 4; i++) step(1'b1, 5'(i + 1), 32'(i), 1'b0, 5'd0, 32'd0, 5'd7);
      step(1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'd0, 5'd7);
      check("starve_drain_addr", 32'(dut.pipe_stall_WB), 32'd0);
      step(1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'd0, 5'd0);
      idle_step();

      // Depth 2, busy pipeline, three back-to-back offers: third is refused.
      step(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA, 5'd0);
      step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB, 5'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC, 5'd11);
      for (int i = 0; i < 4; i++) idle_step();

      // Pipeline write to r0 lets the MDU drain; MDU result for r0 is discarded.
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h88, 5'd0);
      step(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 5'd8);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, 5'd0);
      idle_step();

      // Full buffer with a same-cycle drain: ready stays low, count drops to one.
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD, 5'd0);
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hE, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF, 5'd14);
      check("full_pop_count", 32'(dut.u_fifo.count), 32'd1);
      for (int i = 0; i < 3; i++) idle_step();

      // Reset with two entries queued: nothing from them is written afterwards.
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 5'd0);
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h21, 5'd0);
      pulse_reset();
      check("post_rst_count", 32'(dut.u_fifo.count), 32'd0);
      for (int i = 0; i < 3; i++) idle_step();

      // Random traffic, mostly busy pipeline so forced drains occur.
      for (int i = 0; i < 600; i++) begin
         logic [4:0] h;
         h = 5'($urandom_range(0, 31));
         if (mq.size() > 0 && $urandom_range(0, 1) == 1) h = mq[0][36:32];
         step(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom, h);
         if (i == 300) pulse_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive blocked cycles before a forced MDU drain; legal range 1..15.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: MDU result buffer entries; legal values 2 or 4.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pipe_wr_en_WB  in  1  pipeline writeback requests a register write this cycle.
REQ-006 SHALL have port pipe_rd_WB  in  5  pipeline destination register.
REQ-007 SHALL have port write_data_WB  in  32  pipeline writeback data.
REQ-008 SHALL have port mdu_valid  in  1  multi-cycle unit offers a result.
REQ-009 SHALL have port mdu_rd  in  5  MDU destination register.
REQ-010 SHALL have port mdu_data  in  32  MDU result.
REQ-011 SHALL have port mdu_ready  out  1  arbiter accepts the MDU result this cycle.
REQ-012 SHALL have port hazard_rd  in  5  decode-stage source register query.
REQ-013 SHALL have port hazard_hit  out  1  hazard_rd matches a buffered MDU result not yet written.
REQ-014 SHALL have port pipe_stall_WB  out  1  pipeline must hold its writeback inputs this cycle.
REQ-015 SHALL have ports rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32: single register-file write port.

Function
REQ-016 SHALL accept an MDU result on the edge where mdu_valid and mdu_ready are both 1, pushing {mdu_rd, mdu_data} into the FIFO.
REQ-017 SHALL drive mdu_ready = 1 exactly when the registered FIFO count is below FIFO_DEPTH; a same-cycle drain SHALL NOT raise mdu_ready when the FIFO is full.
REQ-018 SHALL treat a pipeline request as live when pipe_wr_en_WB = 1, pipe_rd_WB != 0 and pipe_stall_WB = 0.
REQ-019 SHALL, with a live pipeline request, drive rf_we = 1, rf_waddr = pipe_rd_WB, rf_wdata = write_data_WB combinationally in the same cycle, with zero latency.
REQ-020 SHALL, without a live pipeline request and with the FIFO non-empty, pop the head and drive rf_we/rf_waddr/rf_wdata from it in that cycle.
REQ-021 SHALL pop a head entry whose rd = 0 without asserting rf_we.
REQ-022 SHALL hold a 4-bit starvation counter: +1 each cycle the FIFO is non-empty and the head is not popped; cleared on any pop or when the FIFO is empty.
REQ-023 SHALL assert pipe_stall_WB combinationally when counter = STARVE_LIMIT; in that cycle it SHALL pop the head regardless of pipe_wr_en_WB.
REQ-024 SHALL give an MDU result accepted at cycle N its earliest rf write at cycle N+1; there is no same-cycle bypass.
REQ-025 SHALL drive hazard_hit = 1 when hazard_rd != 0 and it matches the rd of any valid FIFO entry, including the entry popped this cycle.
REQ-026 SHALL drive rf_we = 0 and rf_waddr = 0, rf_wdata = 0 in cycles with no write.
REQ-027 SHALL, on simultaneous push and pop with the count below FIFO_DEPTH, keep the count unchanged and preserve FIFO order.

Reset
REQ-028 SHALL, while rst_n = 0, clear the FIFO count, read/write pointers and starvation counter, giving mdu_ready = 1, pipe_stall_WB = 0, hazard_hit = 0 and rf_we = 0.
REQ-029 SHALL discard buffered MDU results when reset asserts mid-operation; the MDU is reset alongside.

Structure
REQ-030 SHALL place typedef wb_req_t {rd[4:0], data[31:0]} and the default STARVE_LIMIT and FIFO_DEPTH constants in shared package wb_pkg.
REQ-031 SHALL implement the buffer as sub-module wb_fifo (push/pop/full/empty/count, entry-valid vector for hazard compare).

Verification
REQ-032 SHALL cover: idle pipeline, mdu push {rd=5, data=0x1234} at cycle 0 -> rf_we=1, waddr=5, wdata=0x1234 at cycle 1; hazard_hit=1 for hazard_rd=5 at cycle 0+.
REQ-033 SHALL cover: pipeline writes every cycle, one MDU entry queued, STARVE_LIMIT=4 -> pipe_stall_WB=1 in exactly the 5th cycle after enqueue, with the MDU entry written in that cycle and the pipeline write on the next cycle.
REQ-034 SHALL cover: FIFO_DEPTH=2, pipeline busy, three consecutive mdu_valid -> mdu_ready=0 on the third until a pop; entries written in order.
REQ-035 SHALL cover: pipe_rd_WB=0 with pipe_wr_en_WB=1 and a queued MDU entry -> MDU entry drains that cycle; MDU rd=0 entry -> popped, rf_we=0.
REQ-036 SHALL cover: rst_n low for one cycle with 2 entries queued -> count=0, mdu_ready=1, no rf writes of the discarded entries after release.
REQ-037 SHALL cover: full FIFO with a same-cycle pop -> mdu_ready stays 0 that cycle and the count drops to 1.
